// File: rtl/coeff_scanner.sv
`default_nettype none
// ============================================================================
// Module   : coeff_scanner
// Purpose  : Reorders a quantised 4x4 block into scan order and streams
//            (run, level) pairs plus CAVLC block statistics.
// Options  : FIELD_SCAN_EN adds the field_scan input and the field order.
// Revision : 1.0
// ============================================================================
module coeff_scanner #(
   parameter int BIT_LENGTH = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [BIT_LENGTH:0]   coeffs [15:0],
   input  logic                  in_valid,
`ifdef FIELD_SCAN_EN
   input  logic                  field_scan,
`endif
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            out_run,
   output logic [BIT_LENGTH:0]   out_level,
   output logic                  out_last,
   output logic [4:0]            total_coeffs,
   output logic [1:0]            trailing_ones,
   output logic                  block_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [BIT_LENGTH:0] LEVEL_ZERO = {(BIT_LENGTH+1){1'b0}};
   localparam logic [BIT_LENGTH:0] LEVEL_P1   = {{BIT_LENGTH{1'b0}}, 1'b1};
   localparam logic [BIT_LENGTH:0] LEVEL_M1   = {(BIT_LENGTH+1){1'b1}};

   function automatic logic [3:0] frame_pos(input logic [3:0] pos);
      case (pos)
         4'd0:    return 4'd0;
         4'd1:    return 4'd1;
         4'd2:    return 4'd4;
         4'd3:    return 4'd8;
         4'd4:    return 4'd5;
         4'd5:    return 4'd2;
         4'd6:    return 4'd3;
         4'd7:    return 4'd6;
         4'd8:    return 4'd9;
         4'd9:    return 4'd12;
         4'd10:   return 4'd13;
         4'd11:   return 4'd10;
         4'd12:   return 4'd7;
         4'd13:   return 4'd11;
         4'd14:   return 4'd14;
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [3:0] field_pos(input logic [3:0] pos);
      case (pos)
         4'd0:    return 4'd0;
         4'd1:    return 4'd4;
         4'd2:    return 4'd1;
         4'd3:    return 4'd8;
         4'd4:    return 4'd12;
         4'd5:    return 4'd5;
         4'd6:    return 4'd9;
         4'd7:    return 4'd13;
         4'd8:    return 4'd2;
         4'd9:    return 4'd6;
         4'd10:   return 4'd10;
         4'd11:   return 4'd14;
         4'd12:   return 4'd3;
         4'd13:   return 4'd7;
         4'd14:   return 4'd11;
         default: return 4'd15;
      endcase
   endfunction

   state_t              state;
   logic [BIT_LENGTH:0] scan_buf [16];
   logic [3:0]          idx;
   logic [3:0]          run;
   logic [3:0]          last_idx;
   logic                scanning;

   logic                field_sel;
   logic [BIT_LENGTH:0] scan_in [16];
   logic [4:0]          nz_count;
   logic [3:0]          last_pos;
   logic [1:0]          t1_count;
   logic                any_nz;
   logic                advance;

`ifdef FIELD_SCAN_EN
   assign field_sel = field_scan;
`else
   assign field_sel = 1'b0;
`endif

   assign in_ready = (state == S_IDLE) && enable;
   assign advance  = scanning && !(out_valid && !out_ready);

   always_comb begin
      for (int p = 0; p < 16; p++) begin
         scan_in[p] = coeffs[field_sel ? field_pos(4'(p)) : frame_pos(4'(p))];
      end
   end

   // Counting upward, a non-unit level resets the trailing-ones run, so the
   // final value is the run of unit levels at the high-frequency end.
   always_comb begin
      nz_count = 5'd0;
      last_pos = 4'd0;
      t1_count = 2'd0;
      any_nz   = 1'b0;
      for (int p = 0; p < 16; p++) begin
         if (scan_in[p] != LEVEL_ZERO) begin
            any_nz   = 1'b1;
            nz_count = nz_count + 5'd1;
            last_pos = 4'(p);
            if (scan_in[p] == LEVEL_P1 || scan_in[p] == LEVEL_M1) begin
               if (t1_count != 2'd3) begin
                  t1_count = t1_count + 2'd1;
               end
            end else begin
               t1_count = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         idx           <= 4'd0;
         run           <= 4'd0;
         last_idx      <= 4'd0;
         scanning      <= 1'b0;
         out_valid     <= 1'b0;
         out_run       <= 4'd0;
         out_level     <= LEVEL_ZERO;
         out_last      <= 1'b0;
         total_coeffs  <= 5'd0;
         trailing_ones <= 2'd0;
         block_done    <= 1'b0;
         for (int p = 0; p < 16; p++) begin
            scan_buf[p] <= LEVEL_ZERO;
         end
      end else if (enable) begin
         block_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  for (int p = 0; p < 16; p++) begin
                     scan_buf[p] <= scan_in[p];
                  end
                  last_idx      <= last_pos;
                  total_coeffs  <= nz_count;
                  trailing_ones <= t1_count;
                  idx           <= 4'd0;
                  run           <= 4'd0;
                  scanning      <= any_nz;
                  if (any_nz) begin
                     state <= S_SCAN;
                  end else begin
                     state      <= S_DONE;
                     block_done <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     state      <= S_DONE;
                     block_done <= 1'b1;
                  end
               end
               // A freshly loaded pair overrides the clear above.
               if (advance) begin
                  if (scan_buf[idx] == LEVEL_ZERO) begin
                     run <= run + 4'd1;
                  end else begin
                     out_run   <= run;
                     out_level <= scan_buf[idx];
                     out_last  <= (idx == last_idx);
                     out_valid <= 1'b1;
                     run       <= 4'd0;
                  end
                  idx <= idx + 4'd1;
                  if (idx == last_idx) begin
                     scanning <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/coeff_scanner.md
# coeff_scanner

Reorders one quantised 4x4 coefficient block from `transformcoder` into scan order and streams it out as (run, level) pairs, with block statistics for the downstream CAVLC entropy coder. It sits directly downstream of `transformcoder`. It accepts a whole block in one handshake, serialises the non-zero levels with a valid/ready output, and pulses a per-block completion flag.

## Interface
- `BIT_LENGTH`, default 31: MSB index of each coefficient; coefficients are `BIT_LENGTH+1` bits, two's complement.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: one clock; reset is synchronous and active-low (`reset`=0 resets on the next `clk` rising edge).
- `enable` input 1: when low, all state and outputs freeze and `in_ready`=0.
- `coeffs[15:0]` input `[BIT_LENGTH:0]` each: quantised block, raster order (index = row*4+col).
- `in_valid` input 1: block present on `coeffs`.
- `in_ready` output 1: block capture possible, equal to (state==IDLE && enable), combinational.
- `out_valid` output 1: pair present on the output.
- `out_ready` input 1: consumer accepts the pair.
- `out_run` output 4: zeros in scan order since the previous non-zero level (or since scan position 0).
- `out_level` output `[BIT_LENGTH:0]`: non-zero level, signed.
- `out_last` output 1: this pair is the final non-zero level of the block.
- `total_coeffs` output 5: non-zero count, 0..16.
- `trailing_ones` output 2: count of consecutive ±1 levels at the high-frequency end, capped at 3.
- `block_done` output 1: one-cycle pulse after the block's last pair is accepted.

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE:**
  - On `in_valid && in_ready`, capture the 16 coefficients reordered to scan order.
  - In the same cycle compute `last_idx` (highest non-zero scan index), `total_coeffs`, and `trailing_ones`, and register them.
  - Go to SCAN with idx=0 and run=0.
  - If the block is all zero, go to DONE instead.
- Frame zigzag order (scan position to raster index): 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- **SCAN:** the output register is 1-deep. The scanner advances on each enabled cycle where !(`out_valid` && !`out_ready`).
  - If buf[idx]==0: run++, idx++.
  - Else: load `out_run`=run, `out_level`=buf[idx], `out_last`=(idx==last_idx); set `out_valid`=1, run=0, idx++.
  - Scanning stops after `last_idx`; trailing zeros are not walked.
- When the `out_last` pair completes its handshake, go to DONE. `out_valid` drops unless a new pair is loaded (none are after the last).
- **DONE:** `block_done`=1 for exactly one cycle, then IDLE.
  - `total_coeffs` and `trailing_ones` are valid from the DONE cycle and held until the next capture.
- `trailing_ones`: walk from `last_idx` downward, counting levels equal to +1 or −1. Stop at the first level of other magnitude or at 3.
- Reset values:
  - `out_valid`, `out_run`, `out_level`, `out_last`, `total_coeffs`, `trailing_ones`, `block_done` are all 0.
  - State is IDLE, so `in_ready`=`enable`.
- Reset mid-block: the block is discarded, no `block_done`, IDLE on the next cycle.
- `enable` low mid-block: full freeze. A pending `out_valid` stays high and a handshake is not honoured while `enable`=0.

## Timing
- Capture at cycle T.
- Scan position k (k ≤ `last_idx`) is examined at T+1+k plus any backpressure stall cycles. Its pair appears with `out_valid` on the following cycle.
- With `out_ready` held high:
  - One scan position is examined per cycle.
  - `block_done` occurs at T+`last_idx`+3.
  - `in_ready` is high again at T+`last_idx`+4.
- All-zero block: `block_done` at T+1, `in_ready` at T+2, no pairs.
- `out_run`, `out_level`, and `out_last` are stable while `out_valid` && !`out_ready`.
- `in_valid` is ignored outside IDLE; the upstream stage holds the block until `in_ready`.

## Configuration
- `FIELD_SCAN_EN` defined:
  - Adds input port `field_scan` (1 bit), sampled at capture.
  - `field_scan`=1 selects field order 0,4,1,8,12,5,9,13,2,6,10,14,3,7,11,15; `field_scan`=0 selects frame zigzag.
- `FIELD_SCAN_EN` undefined: no port, frame zigzag only.

## Test plan
- All-zero block, `out_ready`=1 -> no `out_valid`; `block_done` at T+1 with `total_coeffs`=0 and `trailing_ones`=0.
- `coeffs[0]`=5, rest 0 -> one pair (run 0, level 5, last 1) at T+2; `block_done` at T+3; `total_coeffs`=1, `trailing_ones`=0.
- `coeffs[1]`=3, `coeffs[15]`=−1 -> pairs (1, 3, 0) then (13, −1, 1); `total_coeffs`=2, `trailing_ones`=1.
- `coeffs[0,1,4,8]`=1,−1,1,−1 with `out_ready` low for 5 cycles on the first pair -> the first pair is held stable with none lost. Output is four pairs at run 0 with levels 1,−1,1,−1; `total_coeffs`=4, `trailing_ones`=3.
- `reset`=0 for one cycle during SCAN -> next cycle `out_valid`=0, `block_done` never pulses, `in_ready`=1. The next block (`coeffs[0]`=5) is processed normally.
- With `FIELD_SCAN_EN` defined and `field_scan`=1, `coeffs[4]`=7 -> pair (1, 7, 1).
